// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bus responder: FSM state, request/response
// records at the default bus widths, and the full-word byte-enable constant.
package reg_bus_pkg;

    localparam int unsigned REG_BUS_AW = 12;
    localparam int unsigned REG_BUS_DW = 32;
    localparam int unsigned REG_BUS_NB = REG_BUS_DW / 8;

    localparam logic [REG_BUS_NB-1:0] BE_ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } reg_bus_state_e;

    typedef struct packed {
        logic                  write;
        logic [REG_BUS_AW-1:0] addr;
        logic [REG_BUS_DW-1:0] wdata;
        logic [REG_BUS_NB-1:0] be;
    } reg_bus_req_t;

    typedef struct packed {
        logic [REG_BUS_DW-1:0] rdata;
        logic                  error;
    } reg_bus_rsp_t;

endpackage

// File: rtl/reg_bus_addr_decode.sv
// Combinational address decode: word index plus hit for aligned, in-range
// accesses. With REG_BUS_WSTRB_CHECK_EN defined, partial-word writes miss.
module reg_bus_addr_decode
    import reg_bus_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned NumRegs = 16
) (
    input  logic [AW-1:0]   addr_i,
    input  logic            write_i,
    input  logic [DW/8-1:0] be_i,
    output logic            hit_o,
    output logic [AW-3:0]   idx_o
);

    logic aligned;
    logic in_range;
    logic strobe_ok;

    assign idx_o    = addr_i[AW-1:2];
    assign aligned  = (addr_i[1:0] == 2'b00);
    assign in_range = (64'(idx_o) < 64'(NumRegs));

`ifdef REG_BUS_WSTRB_CHECK_EN
    // Empty strobes stay legal: they are a harmless no-op, not a sub-word write.
    assign strobe_ok = !write_i || (be_i == '0) || (&be_i);
`else
    logic unused_strobe;
    assign unused_strobe = write_i ^ (^be_i);
    assign strobe_ok     = 1'b1;
`endif

    assign hit_o = aligned && in_range && strobe_ok;

endmodule

// File: rtl/reg_bus_responder.sv
// Register-bank bus responder: one outstanding request, one-cycle access pulse,
// then a held response. Optional strobe checking via REG_BUS_WSTRB_CHECK_EN.
module reg_bus_responder
    import reg_bus_pkg::*;
#(
    parameter int unsigned AW      = 12,
    parameter int unsigned DW      = 32,
    parameter int unsigned NumRegs = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [AW-1:0]         req_addr_i,
    input  logic [DW-1:0]         req_wdata_i,
    input  logic [DW/8-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DW-1:0]         rsp_rdata_o,
    output logic                  rsp_error_o,
    output logic [NumRegs-1:0]    reg_we_o,
    output logic [NumRegs-1:0]    reg_re_o,
    output logic [DW-1:0]         reg_wdata_o,
    output logic [DW/8-1:0]       reg_be_o,
    input  logic [NumRegs*DW-1:0] reg_rdata_i
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned IW = AW - 2;

    reg_bus_state_e     state_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic               rsp_error_q;
    logic [DW-1:0]      rsp_rdata_q;
    logic [NumRegs-1:0] reg_we_q;
    logic [NumRegs-1:0] reg_re_q;
    logic [DW-1:0]      reg_wdata_q;
    logic [NB-1:0]      reg_be_q;
    logic               write_q;
    logic               hit_q;
    logic [IW-1:0]      idx_q;

    logic               dec_hit;
    logic [IW-1:0]      dec_idx;
    logic [NumRegs-1:0] pulse_d;
    logic [DW-1:0]      rdata_d;
    logic               req_fire;

    reg_bus_addr_decode #(
        .AW      (AW),
        .DW      (DW),
        .NumRegs (NumRegs)
    ) u_decode (
        .addr_i  (req_addr_i),
        .write_i (req_write_i),
        .be_i    (req_be_i),
        .hit_o   (dec_hit),
        .idx_o   (dec_idx)
    );

    assign req_fire = req_valid_i && req_ready_q;

    always_comb begin
        pulse_d = '0;
        for (int k = 0; k < NumRegs; k++) begin
            if (dec_idx == IW'(k)) begin
                pulse_d[k] = 1'b1;
            end
        end
    end

    // Sampled at the end of ACCESS, before any read-to-clear field updates.
    always_comb begin
        rdata_d = '0;
        for (int k = 0; k < NumRegs; k++) begin
            if (idx_q == IW'(k)) begin
                rdata_d = reg_rdata_i[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            reg_we_q    <= '0;
            reg_re_q    <= '0;
            reg_wdata_q <= '0;
            reg_be_q    <= '0;
            write_q     <= 1'b0;
            hit_q       <= 1'b0;
            idx_q       <= '0;
        end else begin
            reg_we_q <= '0;
            reg_re_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_fire) begin
                        req_ready_q <= 1'b0;
                        write_q     <= req_write_i;
                        hit_q       <= dec_hit;
                        idx_q       <= dec_idx;
                        reg_wdata_q <= req_wdata_i;
                        reg_be_q    <= req_be_i;
                        if (dec_hit && req_write_i && (req_be_i != '0)) begin
                            reg_we_q <= pulse_d;
                        end
                        if (dec_hit && !req_write_i) begin
                            reg_re_q <= pulse_d;
                        end
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_valid_q <= 1'b1;
                    rsp_error_q <= !hit_q;
                    rsp_rdata_q <= (hit_q && !write_q) ? rdata_d : '0;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_error_o = rsp_error_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign reg_we_o    = reg_we_q;
    assign reg_re_o    = reg_re_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_be_o    = reg_be_q;

    a_single_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(reg_we_o | reg_re_o));

    a_rsp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_valid_o && !rsp_ready_i) |=>
            (rsp_valid_o && $stable(rsp_rdata_o) && $stable(rsp_error_o)));

endmodule
